// File: rtl/thor_pkg.sv
// Shared dual-rail encodings and lane state for the thor NCL OR stage.
package thor_pkg;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    LANE_NULL  = 2'b00,
    LANE_DATA0 = 2'b01,
    LANE_DATA1 = 2'b10
  } lane_e;

  function automatic logic dr_is_data(input logic [1:0] x);
    return (x == DR_ZERO) || (x == DR_ONE);
  endfunction

endpackage

// File: rtl/thor_bit.sv
// One dual-rail OR lane: hysteresis register plus error pulse.
// Error detection is present only with THOR_ERR_CHECK_EN defined.
module thor_bit
  import thor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic       r0_o,
  output logic       r1_o,
  output logic       data_d_o,
  output logic       null_d_o,
  output logic       err_o
);

  lane_e state_q, state_d;
  logic  a_dat, b_dat;
  logic  a_nul, b_nul;
  logic  capture;

  assign a_dat   = dr_is_data(a_i);
  assign b_dat   = dr_is_data(b_i);
  assign a_nul   = (a_i == DR_NULL);
  assign b_nul   = (b_i == DR_NULL);
  assign capture = (state_q == LANE_NULL) && a_dat && b_dat;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LANE_NULL: begin
        if (a_dat && b_dat) begin
          state_d = (a_i == DR_ONE || b_i == DR_ONE)
                  ? LANE_DATA1 : LANE_DATA0;
        end
      end
      LANE_DATA0, LANE_DATA1: begin
        if (a_nul && b_nul) state_d = LANE_NULL;
      end
      default: state_d = LANE_NULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LANE_NULL;
    else        state_q <= state_d;
  end

  assign r0_o     = (state_q == LANE_DATA0);
  assign r1_o     = (state_q == LANE_DATA1);
  assign data_d_o = (state_d != LANE_NULL);
  assign null_d_o = (state_d == LANE_NULL);

`ifdef THOR_ERR_CHECK_EN
  // Operand values latched at capture; a later differing DATA means no NULL came between.
  logic [1:0] op_q, op_d;
  logic       illegal;
  logic       changed;

  assign illegal = (a_i == DR_ILLEGAL) || (b_i == DR_ILLEGAL);
  assign changed = (state_q != LANE_NULL) &&
                   ((a_dat && (a_i[1] != op_q[1])) ||
                    (b_dat && (b_i[1] != op_q[0])));

  always_comb begin
    op_d = op_q;
    if (capture) op_d = {a_i[1], b_i[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) op_q <= 2'b00;
    else        op_q <= op_d;
  end

  assign err_o = illegal || changed;
`else
  logic unused_cap;
  assign unused_cap = capture;
  assign err_o      = 1'b0;
`endif

endmodule

// File: rtl/thor_dual_rail_or.sv
// Clocked dual-rail OR stage: WIDTH lanes, done completion, sticky err.
// Optional error detection selected by THOR_ERR_CHECK_EN.
module thor_dual_rail_or
  import thor_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] result0,
  output logic [WIDTH-1:0] result1,
  output logic             done,
  output logic             err
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] null_d;
  logic [WIDTH-1:0] err_p;
  logic             done_q, done_d;
  logic             err_q, err_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    thor_bit u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_i      ({a1[i], a0[i]}),
      .b_i      ({b1[i], b0[i]}),
      .r0_o     (result0[i]),
      .r1_o     (result1[i]),
      .data_d_o (data_d[i]),
      .null_d_o (null_d[i]),
      .err_o    (err_p[i])
    );
  end

  // done tracks next lane state so it moves on the same edge as the results.
  always_comb begin
    done_d = done_q;
    if (&data_d)      done_d = 1'b1;
    else if (&null_d) done_d = 1'b0;
    err_d = err_q | (|err_p);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_thor_dual_rail_or.sv
// Scoreboard bench for thor_dual_rail_or (WIDTH = 4), directed plus random.
module tb_thor_dual_rail_or;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [W-1:0] result0, result1;
  logic         done, err;

  thor_dual_rail_or #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .result0(result0), .result1(result1),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic         dn;
    logic         er;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference: lane value -1 = NULL, 0/1 = DATA value.
  int   st[W];
  bit   cap_a[W], cap_b[W];
  bit   m_done, m_err;

`ifdef THOR_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic step(input logic [W-1:0] ia0, ia1, ib0, ib1,
                      input logic irst);
    exp_t e;
    bit   alld, alln;
    @(negedge clk);
    a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1; rst_n = irst;
    if (!irst) begin
      for (int i = 0; i < W; i++) st[i] = -1;
      m_done = 0;
      m_err  = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        logic [1:0] ca, cb;
        bit ad, bd;
        ca = {ia1[i], ia0[i]};
        cb = {ib1[i], ib0[i]};
        ad = (ca == 2'b01) || (ca == 2'b10);
        bd = (cb == 2'b01) || (cb == 2'b10);
        if (ca == 2'b11 || cb == 2'b11) m_err = 1;
        if (st[i] >= 0) begin
          if ((ad && ca[1] != cap_a[i]) || (bd && cb[1] != cap_b[i]))
            m_err = 1;
          if (ca == 2'b00 && cb == 2'b00) st[i] = -1;
        end else if (ad && bd) begin
          st[i]    = (ca[1] || cb[1]) ? 1 : 0;
          cap_a[i] = ca[1];
          cap_b[i] = cb[1];
        end
      end
      alld = 1; alln = 1;
      for (int i = 0; i < W; i++) begin
        if (st[i] < 0) alld = 0;
        else           alln = 0;
      end
      if (alld)      m_done = 1;
      else if (alln) m_done = 0;
    end
    for (int i = 0; i < W; i++) begin
      e.r0[i] = (st[i] == 0);
      e.r1[i] = (st[i] == 1);
    end
    e.dn = m_done;
    e.er = ERR_EN && m_err;
    q.push_back(e);
  endtask

  task automatic all(input logic [1:0] ca, input logic [1:0] cb);
    step({W{ca[0]}}, {W{ca[1]}}, {W{cb[0]}}, {W{cb[1]}}, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result0", result0, e.r0);
        chk("result1", result1, e.r1);
        chk("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e.dn});
        chk("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, e.er});
      end
    end
  end

  logic [1:0] ca_r[W], cb_r[W];
  logic [1:0] va[W], vb[W];
  bit         phase;

  initial begin
    logic [W-1:0] ra0, ra1, rb0, rb1;
    for (int i = 0; i < W; i++) st[i] = -1;
    m_done = 0; m_err = 0;

    step('0, '0, '0, '0, 1'b0);
    step('0, '0, '0, '0, 1'b0);
    all(2'b00, 2'b00);
    // a = 0, b = NULL holds; then b = 0 captures
    all(2'b01, 2'b00);
    all(2'b01, 2'b01);
    all(2'b00, 2'b00);
    all(2'b01, 2'b10);
    all(2'b00, 2'b00);
    all(2'b10, 2'b00);
    all(2'b10, 2'b10);
    // a alone returns to NULL: hold
    all(2'b00, 2'b10);
    all(2'b00, 2'b10);
    all(2'b00, 2'b00);
    // staggered lanes
    for (int k = 1; k <= W; k++) begin
      logic [W-1:0] m;
      m = W'((1 << k) - 1);
      step(m, '0, m, '0, 1'b1);
    end
    for (int k = W - 1; k >= 0; k--) begin
      logic [W-1:0] m;
      m = W'((1 << k) - 1);
      step(m, '0, m, '0, 1'b1);
    end
    // illegal code, sticky err, then reset mid-DATA
    all(2'b11, 2'b01);
    all(2'b00, 2'b00);
    all(2'b10, 2'b01);
    all(2'b01, 2'b01);
    all(2'b10, 2'b01);
    step('1, '0, '1, '0, 1'b0);
    all(2'b00, 2'b00);

    // random wavefronts: each operand drifts toward a shared phase
    phase = 0;
    for (int i = 0; i < W; i++) begin
      ca_r[i] = 2'b00; cb_r[i] = 2'b00;
    end
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        phase = ~phase;
        for (int i = 0; i < W; i++) begin
          va[i] = $urandom_range(1) ? 2'b10 : 2'b01;
          vb[i] = $urandom_range(1) ? 2'b10 : 2'b01;
        end
      end
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(9) < 6) ca_r[i] = phase ? va[i] : 2'b00;
        if ($urandom_range(9) < 6) cb_r[i] = phase ? vb[i] : 2'b00;
        if ($urandom_range(99) == 0) ca_r[i] = 2'b11;
        if ($urandom_range(99) == 0) cb_r[i] = ~vb[i];
        ra0[i] = ca_r[i][0]; ra1[i] = ca_r[i][1];
        rb0[i] = cb_r[i][0]; rb1[i] = cb_r[i][1];
      end
      step(ra0, ra1, rb0, rb1, ($urandom_range(59) != 0));
    end

    repeat (3) @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/thor_dual_rail_or.md
# thor_dual_rail_or

Clocked dual-rail (NULL Convention Logic) OR stage. It accepts WIDTH pairs of dual-rail operands and produces a WIDTH-bit dual-rail OR result. Per-bit hysteresis follows NCL threshold-gate rules: an output bit goes DATA only on complete DATA inputs, and returns to NULL only on complete NULL inputs. It sits between NCL pipeline registers in the async-CPU datapath, where the logic is emulated synchronously on one clock.

## Interface
- WIDTH, default 1: number of independent dual-rail bit lanes.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset is synchronous and active-low.
- a0  in  WIDTH  operand A rail-0 (asserted = logic 0).
- a1  in  WIDTH  operand A rail-1 (asserted = logic 1).
- b0  in  WIDTH  operand B rail-0.
- b1  in  WIDTH  operand B rail-1.
- result0  out  WIDTH  result rail-0 (registered).
- result1  out  WIDTH  result rail-1 (registered).
- done  out  1  completion: 1 = all lanes DATA, 0 = all lanes NULL (registered).
- err  out  1  sticky protocol-error flag (registered).

## Operation
- Encoding per lane, {x1,x0}: 00 = NULL, 01 = DATA 0, 10 = DATA 1, 11 = illegal.
- Each lane holds a state of NULL, DATA0 or DATA1. result0 and result1 mirror this state: NULL = 00, DATA0 = result0 high, DATA1 = result1 high.
- NULL -> DATA: when both a and b are DATA (legal, non-NULL), the lane captures the OR.
  - result1 = 1 if a1 or b1.
  - result0 = 1 only if a0 and b0.
- DATA -> NULL: when both a and b are NULL.
- All other input combinations hold the state. This covers:
  - partial DATA (one operand still NULL);
  - partial NULL;
  - a DATA-to-DATA change without an intervening NULL wavefront.
- An illegal code (11) on any input rail pair is never captured and the lane holds.
- done:
  - set when every lane is DATA;
  - cleared when every lane is NULL;
  - held otherwise (mixed lanes).
- err is set, when enabled, on any of:
  - an illegal input code on any lane;
  - a DATA-to-DATA input change while the lane is in DATA.
  - Once set, err stays set until reset.

## Timing
- Latency: outputs reflect a qualifying input wavefront 1 clk after the sampling edge.
- No handshake ports. The upstream stage must alternate complete-DATA and complete-NULL wavefronts, using done as the acknowledge.
- Reset (rst_n = 0 at a rising edge):
  - result0 and result1 go to all zeros (NULL);
  - done = 0;
  - err = 0.
  - Reset overrides any concurrent capture. In-flight DATA is discarded.
- If both operands go from NULL to complete DATA in the same cycle, the lane captures them on that edge.
- If the inputs go DATA -> NULL -> DATA within a single clock period, that wavefront is not seen. Upstream must hold each wavefront at least 1 cycle.

## Configuration
- THOR_ERR_CHECK_EN defined: illegal-code and missing-NULL detection is built in, and err behaves as above.
- THOR_ERR_CHECK_EN undefined: the detection logic is removed and err is tied to 0. Lane behaviour is identical in both cases.

## Structure
- Package thor_pkg holds:
  - the 2-bit dual-rail encoding constants DR_NULL, DR_ZERO, DR_ONE, DR_ILLEGAL;
  - the lane-state typedef (NULL/DATA0/DATA1).
- Sub-module thor_bit: one lane's hysteresis register and OR logic, plus a per-lane error pulse. The top instantiates WIDTH copies via generate, then reduces them to form done and err.

## Test plan
- Reset, then a = NULL and b = NULL -> result0 = 0, result1 = 0, done = 0, err = 0.
- a = 0 (a0 = 1), b = NULL -> outputs stay NULL. Then b = 0 -> next cycle result0 = 1, result1 = 0, done = 1. Then both NULL -> next cycle result = 00, done = 0.
- a = 0, b = 1 (b1 = 1) -> result1 = 1. Then a = 1, b = NULL -> stays NULL after the intervening NULL. Then a = 1, b = 1 -> result1 = 1.
- From DATA, a alone returns to NULL -> outputs and done hold DATA until b also returns to NULL.
- With THOR_ERR_CHECK_EN defined, a0 = a1 = 1 -> err = 1 next cycle, lane holds, and err stays set until rst_n = 0.
- WIDTH = 4, lanes going DATA on different cycles -> done rises only after the last lane is DATA, and falls only after the last lane is NULL. Asserting rst_n mid-DATA clears everything next edge.
